exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  MEM-stage exception resolver and PC-redirect sequencer for the 5-stage MIPS core. It is the producer side of the CP0 exception interface.
//  Prioritises per-instruction fault flags and pending interrupts, then drives excepttype/EPC-source/badvaddr into cp0_reg.
//  Flushes the pipeline and hands the new PC to fetch over a valid/ready handshake.
// PARAMETERS
//  EXC_VECTOR  32'hBFC00380  target PC for every exception except ERET
// PORTS
//  clk                  in   1   clock
//  rst                  in   1   synchronous, active-high reset
//  mem_valid            in   1   MEM stage holds a real (non-bubble) instruction
//  mem_pc               in   32  PC of MEM-stage instruction
//  mem_in_delayslot     in   1   MEM instruction is a delay-slot instruction
//  mem_exc_flags        in   9   {eret,adel_ld,ades,trap,ov,brk,sys,ri,adel_if}
//  mem_addr             in   32  data address of MEM load/store
//  int_i                in   6   raw hardware interrupt lines
//  timer_int_i          in   1   timer interrupt from cp0_reg
//  cp0_status_i         in   32  current CP0 Status
//  cp0_cause_i          in   32  current CP0 Cause
//  cp0_epc_i            in   32  current CP0 EPC
//  wb_cp0_we            in   1   MTC0 in WB is writing CP0 this cycle
//  wb_cp0_waddr         in   5   MTC0 destination register
//  wb_cp0_wdata         in   32  MTC0 data
//  redirect_ready       in   1   fetch accepts redirect_pc
//  int_o                out  6   registered interrupt lines, drive cp0_reg.int_i
//  excepttype_o         out  32  exception code into cp0_reg
//  current_inst_addr_o  out  32  = mem_pc
//  is_in_delayslot_o    out  1   = mem_in_delayslot
//  bad_addr_o           out  32  faulting address for AdEL/AdES
//  flush_o              out  1   kill IF..MEM this cycle
//  stall_o              out  1   hold IF/ID while a redirect is pending
//  redirect_valid       out  1   redirect_pc is valid
//  redirect_pc          out  32  new fetch PC
// BEHAVIOUR
//  Reset: state=IDLE. int_o, redirect_valid, redirect_pc, stall_o and flush_o are 0. excepttype_o is 0.
//  int_q <= int_i every cycle. int_o = int_q, with bit 5 modified as described under CONFIGURATION.
//  CP0 forwarding: if wb_cp0_we and waddr==12, use status = wdata.
//   If waddr==13, replace cause[9:8] with wdata[9:8].
//   If waddr==14, use epc = wdata. Otherwise use the cp0_*_i values.
//  IP = {int_o, fwd_cause[9:8]}. The interrupt is pending when status[0]=1, status[1]=0 and |(IP & status[15:8]).
//  Codes are in strict priority order, highest first:
//   int=1 > adel_if=4 > ri=a > sys=8 > brk=9 > ov=c > trap=d > adel_ld=4 > ades=5 > eret=e.
//  The interrupt and all flags are considered only when mem_valid=1. With mem_valid=0 the interrupt stays pending.
//  bad_addr_o = mem_pc for adel_if, mem_addr for adel_ld/ades, otherwise 0.
//  FSM IDLE:
//   - Resolved code != 0 in cycle N: drive excepttype_o combinationally and assert flush_o in cycle N.
//   - cp0_reg commits at edge N+1.
//   - Latch redirect_pc: fwd epc for eret, EXC_VECTOR otherwise. Go to REDIR.
//  FSM REDIR: redirect_valid=1 and stall_o=1. excepttype_o=0 and flush_o=0.
//   - All MEM inputs are ignored.
//   - On redirect_ready, go to IDLE on the next edge; redirect_valid is dropped in that cycle.
//  Minimum detect-to-redirect latency is 1 cycle. Back-to-back exceptions are at least 2 cycles apart.
//  rst in REDIR: go to IDLE and drop redirect_valid the following cycle. The pending redirect is discarded.
//  An MTC0 in WB and the exception in MEM in the same cycle: forwarded values decide both the interrupt gating and the ERET target.
// CONFIGURATION
//  EXC_TIMER_INT_EN defined: int_o[5] = int_q[5] | timer_int_i, so the timer drives IP7.
//  EXC_TIMER_INT_EN undefined: int_o[5] = int_q[5], and timer_int_i is unused.
// STRUCTURE
//  Excepttype codes, CP0 register addresses and EXC_VECTOR belong in the shared defines.vh.
//  One combinational sub-module, exc_prio_enc, takes flags and int_pending and produces {code, bad_addr_sel}.
//  The FSM and forwarding stay in exception_ctrl.
// TESTING
//  1. adel_if=1, ov=1, mem_pc=0x80000004 -> excepttype_o=0x4, bad_addr_o=0x80000004, flush_o=1.
//     Next cycle: redirect_valid=1, redirect_pc=0xBFC00380.
//  2. eret=1, epc=0x80001000, and WB MTC0 to EPC with wdata 0x80002000 in the same cycle
//     -> excepttype_o=0xe, redirect_pc=0x80002000.
//  3. status=0x0000_0401 and int_i[0] raised -> pending one cycle later. With mem_valid=1: excepttype_o=0x1.
//     With mem_valid=0 held 3 cycles: no flush until mem_valid=1.
//  4. Timer test: timer_int_i=1, status=0x8001.
//     With EXC_TIMER_INT_EN: excepttype_o=0x1 and int_o=6'b100000.
//     Without EXC_TIMER_INT_EN: no exception.
//  5. REDIR with redirect_ready low for 4 cycles and a new ov flag presented
//     -> stall_o=1 throughout, no second excepttype, IDLE 1 cycle after ready.
//  6. rst asserted during REDIR -> redirect_valid=0 and stall_o=0 after the edge. A subsequent sys fault gives code 0x8.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception controller: excepttype codes,
// CP0 register addresses, exception vector and fault-flag layout.
package exception_ctrl_pkg;

   localparam logic [31:0] EXC_VECTOR_DFLT = 32'hBFC00380;

   localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
   localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

   localparam logic [4:0] EXC_NONE = 5'h00;
   localparam logic [4:0] EXC_INT  = 5'h01;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BRK  = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;
   localparam logic [4:0] EXC_TRAP = 5'h0d;
   localparam logic [4:0] EXC_ERET = 5'h0e;

   // Source of bad_addr_o
   localparam logic [1:0] BAD_SEL_NONE = 2'd0;
   localparam logic [1:0] BAD_SEL_PC   = 2'd1;
   localparam logic [1:0] BAD_SEL_ADDR = 2'd2;

   typedef struct packed {
      logic eret;
      logic adel_ld;
      logic ades;
      logic trap;
      logic ov;
      logic brk;
      logic sys;
      logic ri;
      logic adel_if;
   } exc_flags_t;

   typedef enum logic {StIdle, StRedir} exc_state_e;

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// exc_prio_enc: combinational priority resolver turning fault flags and a pending
// interrupt into an excepttype code and a bad-address source select.
module exc_prio_enc
   import exception_ctrl_pkg::*;
(
   input  logic       valid,
   input  logic [8:0] flags,
   input  logic       int_pending,
   output logic [4:0] code,
   output logic [1:0] bad_sel
);

   exc_flags_t f;

   always_comb begin
      f       = exc_flags_t'(flags);
      code    = EXC_NONE;
      bad_sel = BAD_SEL_NONE;
      if (valid) begin
         if (int_pending) begin
            code = EXC_INT;
         end else if (f.adel_if) begin
            code    = EXC_ADEL;
            bad_sel = BAD_SEL_PC;
         end else if (f.ri) begin
            code = EXC_RI;
         end else if (f.sys) begin
            code = EXC_SYS;
         end else if (f.brk) begin
            code = EXC_BRK;
         end else if (f.ov) begin
            code = EXC_OV;
         end else if (f.trap) begin
            code = EXC_TRAP;
         end else if (f.adel_ld) begin
            code    = EXC_ADEL;
            bad_sel = BAD_SEL_ADDR;
         end else if (f.ades) begin
            code    = EXC_ADES;
            bad_sel = BAD_SEL_ADDR;
         end else if (f.eret) begin
            code = EXC_ERET;
         end
      end
   end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception resolver and PC-redirect sequencer feeding cp0_reg and fetch.
// Optional EXC_TIMER_INT_EN: OR the CP0 timer interrupt into int_o[5] (IP7).
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_in_delayslot,
   input  logic [8:0]  mem_exc_flags,
   input  logic [31:0] mem_addr,
   input  logic [5:0]  int_i,
   input  logic        timer_int_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we,
   input  logic [4:0]  wb_cp0_waddr,
   input  logic [31:0] wb_cp0_wdata,
   input  logic        redirect_ready,
   output logic [5:0]  int_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic        stall_o,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   exc_state_e  state;
   logic [5:0]  int_q;
   logic [31:0] fwd_status;
   logic [1:0]  fwd_ip_sw;
   logic [31:0] fwd_epc;
   logic [7:0]  ip;
   logic        int_pending;
   logic        enc_valid;
   logic [4:0]  code;
   logic [1:0]  bad_sel;
   logic        unused_bits;

`ifdef EXC_TIMER_INT_EN
   assign int_o = {int_q[5] | timer_int_i, int_q[4:0]};
   assign unused_bits = ^{fwd_status[31:16], fwd_status[7:2], cp0_cause_i[31:10],
                          cp0_cause_i[7:0]};
`else
   assign int_o = int_q;
   assign unused_bits = ^{timer_int_i, fwd_status[31:16], fwd_status[7:2],
                          cp0_cause_i[31:10], cp0_cause_i[7:0]};
`endif

   // An MTC0 retiring in WB this cycle must be visible to the exception decision in MEM.
   always_comb begin
      fwd_status = cp0_status_i;
      fwd_ip_sw  = cp0_cause_i[9:8];
      fwd_epc    = cp0_epc_i;
      if (wb_cp0_we) begin
         unique case (wb_cp0_waddr)
            CP0_ADDR_STATUS: fwd_status = wb_cp0_wdata;
            CP0_ADDR_CAUSE:  fwd_ip_sw  = wb_cp0_wdata[9:8];
            CP0_ADDR_EPC:    fwd_epc    = wb_cp0_wdata;
            default: ;
         endcase
      end
   end

   assign ip          = {int_o, fwd_ip_sw};
   assign int_pending = fwd_status[0] & ~fwd_status[1] & (|(ip & fwd_status[15:8]));
   assign enc_valid   = mem_valid & (state == StIdle) & ~rst;

   exc_prio_enc u_prio_enc (
      .valid       (enc_valid),
      .flags       (mem_exc_flags),
      .int_pending (int_pending),
      .code        (code),
      .bad_sel     (bad_sel)
   );

   assign excepttype_o        = {27'd0, code};
   assign flush_o             = (code != EXC_NONE);
   assign current_inst_addr_o = mem_pc;
   assign is_in_delayslot_o   = mem_in_delayslot;

   always_comb begin
      unique case (bad_sel)
         BAD_SEL_PC:   bad_addr_o = mem_pc;
         BAD_SEL_ADDR: bad_addr_o = mem_addr;
         default:      bad_addr_o = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         int_q          <= 6'd0;
         state          <= StIdle;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
         stall_o        <= 1'b0;
      end else begin
         int_q <= int_i;
         unique case (state)
            StIdle: begin
               if (flush_o) begin
                  state          <= StRedir;
                  redirect_valid <= 1'b1;
                  stall_o        <= 1'b1;
                  redirect_pc    <= (code == EXC_ERET) ? fwd_epc : EXC_VECTOR;
               end
            end
            StRedir: begin
               if (redirect_ready) begin
                  state          <= StIdle;
                  redirect_valid <= 1'b0;
                  stall_o        <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a rule-level reference model.
module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_in_delayslot;
   logic [8:0]  mem_exc_flags;
   logic [31:0] mem_addr;
   logic [5:0]  int_i;
   logic        timer_int_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we;
   logic [4:0]  wb_cp0_waddr;
   logic [31:0] wb_cp0_wdata;
   logic        redirect_ready;
   logic [5:0]  int_o;
   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic [31:0] bad_addr_o;
   logic        flush_o;
   logic        stall_o;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [5:0]  m_int_q = '0;
   bit          m_busy = 0;
   logic [31:0] m_rpc = '0;
   logic [4:0]  e_code = '0;
   logic [31:0] e_epc = '0;

   // Flag bit index and code in priority order (after the interrupt)
   int          prio_bit  [9] = '{0, 1, 2, 3, 4, 5, 7, 6, 8};
   logic [4:0]  prio_code [9] = '{5'h4, 5'ha, 5'h8, 5'h9, 5'hc, 5'hd, 5'h4, 5'h5, 5'he};

   always #5 clk = ~clk;

   exception_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_valid           (mem_valid),
      .mem_pc              (mem_pc),
      .mem_in_delayslot    (mem_in_delayslot),
      .mem_exc_flags       (mem_exc_flags),
      .mem_addr            (mem_addr),
      .int_i               (int_i),
      .timer_int_i         (timer_int_i),
      .cp0_status_i        (cp0_status_i),
      .cp0_cause_i         (cp0_cause_i),
      .cp0_epc_i           (cp0_epc_i),
      .wb_cp0_we           (wb_cp0_we),
      .wb_cp0_waddr        (wb_cp0_waddr),
      .wb_cp0_wdata        (wb_cp0_wdata),
      .redirect_ready      (redirect_ready),
      .int_o               (int_o),
      .excepttype_o        (excepttype_o),
      .current_inst_addr_o (current_inst_addr_o),
      .is_in_delayslot_o   (is_in_delayslot_o),
      .bad_addr_o          (bad_addr_o),
      .flush_o             (flush_o),
      .stall_o             (stall_o),
      .redirect_valid      (redirect_valid),
      .redirect_pc         (redirect_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Evaluate the rules on current inputs mid-cycle and compare every output.
   task automatic settle();
      logic [31:0] fs;
      logic [1:0]  fc;
      logic [5:0]  eio;
      logic [7:0]  ip;
      logic [31:0] e_bad;
      bit          pend;
      @(negedge clk);
      fs    = cp0_status_i;
      fc    = cp0_cause_i[9:8];
      e_epc = cp0_epc_i;
      if (wb_cp0_we && wb_cp0_waddr == 5'd12) fs = wb_cp0_wdata;
      if (wb_cp0_we && wb_cp0_waddr == 5'd13) fc = wb_cp0_wdata[9:8];
      if (wb_cp0_we && wb_cp0_waddr == 5'd14) e_epc = wb_cp0_wdata;
      eio = m_int_q;
`ifdef EXC_TIMER_INT_EN
      if (timer_int_i) eio[5] = 1'b1;
`endif
      ip    = {eio, fc};
      pend  = fs[0] && !fs[1] && ((ip & fs[15:8]) != 8'd0);
      e_code = 5'd0;
      e_bad  = 32'd0;
      if (!rst && !m_busy && mem_valid) begin
         if (pend) begin
            e_code = 5'h1;
         end else begin
            for (int i = 0; i < 9; i++) begin
               if (mem_exc_flags[prio_bit[i]]) begin
                  e_code = prio_code[i];
                  if (prio_bit[i] == 0) e_bad = mem_pc;
                  else if (prio_bit[i] == 6 || prio_bit[i] == 7) e_bad = mem_addr;
                  break;
               end
            end
         end
      end
      chk("int_o", {26'd0, int_o}, {26'd0, eio});
      chk("excepttype", excepttype_o, {27'd0, e_code});
      chk("flush", {31'd0, flush_o}, {31'd0, e_code != 5'd0});
      chk("bad_addr", bad_addr_o, e_bad);
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_busy});
      chk("stall", {31'd0, stall_o}, {31'd0, m_busy});
      if (m_busy) chk("redirect_pc", redirect_pc, m_rpc);
      chk("cur_addr", current_inst_addr_o, mem_pc);
      chk("delayslot", {31'd0, is_in_delayslot_o}, {31'd0, mem_in_delayslot});
   endtask

   task automatic tick_edge();
      @(posedge clk);
      if (rst) begin
         m_int_q = '0;
         m_busy  = 0;
         m_rpc   = '0;
      end else begin
         if (m_busy) begin
            if (redirect_ready) m_busy = 0;
         end else if (e_code != 5'd0) begin
            m_busy = 1;
            m_rpc  = (e_code == 5'he) ? e_epc : 32'hBFC00380;
         end
         m_int_q = int_i;
      end
      #1;
   endtask

   task automatic step();
      settle();
      tick_edge();
   endtask

   task automatic quiet();
      rst = 0; mem_valid = 0; mem_pc = 32'h80000000; mem_in_delayslot = 0;
      mem_exc_flags = '0; mem_addr = '0; int_i = '0; timer_int_i = 0;
      cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
      wb_cp0_we = 0; wb_cp0_waddr = '0; wb_cp0_wdata = '0; redirect_ready = 0;
   endtask

   task automatic drain();
      mem_exc_flags = '0; int_i = '0; timer_int_i = 0; cp0_status_i = '0;
      wb_cp0_we = 0; redirect_ready = 1;
      repeat (2) step();
      redirect_ready = 0;
   endtask

   initial begin
      quiet();
      rst = 1;
      tick_edge();
      settle();
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_int_o", {26'd0, int_o}, 32'd0);
      tick_edge();
      rst = 0;
      step();

      // 1: adel_if beats ov
      mem_valid = 1; mem_pc = 32'h80000004; mem_exc_flags = 9'b0_0001_0001;
      settle();
      chk("t1_code", excepttype_o, 32'h4);
      chk("t1_bad", bad_addr_o, 32'h80000004);
      chk("t1_flush", {31'd0, flush_o}, 32'd1);
      tick_edge();
      mem_exc_flags = '0;
      settle();
      chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
      chk("t1_rpc", redirect_pc, 32'hBFC00380);
      tick_edge();
      drain();

      // 2: ERET with same-cycle MTC0 to EPC
      mem_exc_flags = 9'h100; cp0_epc_i = 32'h80001000;
      wb_cp0_we = 1; wb_cp0_waddr = 5'd14; wb_cp0_wdata = 32'h80002000;
      settle();
      chk("t2_code", excepttype_o, 32'he);
      tick_edge();
      mem_exc_flags = '0; wb_cp0_we = 0;
      settle();
      chk("t2_rpc", redirect_pc, 32'h80002000);
      tick_edge();
      drain();

      // 3: hardware interrupt held off by bubbles
      cp0_status_i = 32'h0000_0401; int_i = 6'b000001; mem_valid = 0;
      step();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t3_noflush", {31'd0, flush_o}, 32'd0);
         tick_edge();
      end
      mem_valid = 1;
      settle();
      chk("t3_code", excepttype_o, 32'h1);
      tick_edge();
      drain();

      // 4: timer interrupt on IP7
      cp0_status_i = 32'h0000_8001; timer_int_i = 1;
      settle();
`ifdef EXC_TIMER_INT_EN
      chk("t4_code", excepttype_o, 32'h1);
      chk("t4_int_o", {26'd0, int_o}, 32'h20);
`else
      chk("t4_code", excepttype_o, 32'h0);
      chk("t4_int_o", {26'd0, int_o}, 32'h0);
`endif
      tick_edge();
      drain();

      // 5: long REDIR with a new fault presented
      mem_exc_flags = 9'h010;
      step();
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t5_stall", {31'd0, stall_o}, 32'd1);
         chk("t5_nocode", excepttype_o, 32'h0);
         tick_edge();
      end
      mem_exc_flags = '0; redirect_ready = 1;
      step();
      redirect_ready = 0;
      settle();
      chk("t5_idle_stall", {31'd0, stall_o}, 32'd0);
      chk("t5_idle_rv", {31'd0, redirect_valid}, 32'd0);
      tick_edge();

      // 6: reset during REDIR, then a sys fault
      mem_exc_flags = 9'h008;
      step();
      mem_exc_flags = '0; rst = 1;
      step();
      rst = 0; mem_exc_flags = 9'h004;
      settle();
      chk("t6_rv", {31'd0, redirect_valid}, 32'd0);
      chk("t6_stall", {31'd0, stall_o}, 32'd0);
      chk("t6_code", excepttype_o, 32'h8);
      tick_edge();
      drain();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] st_pick [4];
         logic [4:0]  addr_pick [4];
         st_pick   = '{32'h0000_0401, 32'h0000_FF01, 32'h0000_8001, 32'h0000_FF03};
         addr_pick = '{5'd12, 5'd13, 5'd14, 5'd9};
         rst              = ($urandom_range(0, 39) == 0);
         mem_valid        = ($urandom_range(0, 4) != 0);
         mem_pc           = $urandom;
         mem_addr         = $urandom;
         mem_in_delayslot = $urandom_range(0, 1);
         mem_exc_flags    = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'd0;
         int_i            = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
         timer_int_i      = ($urandom_range(0, 7) == 0);
         cp0_status_i     = ($urandom_range(0, 2) == 0) ? $urandom : st_pick[$urandom_range(0, 3)];
         cp0_cause_i      = $urandom;
         cp0_epc_i        = $urandom;
         wb_cp0_we        = ($urandom_range(0, 2) == 0);
         wb_cp0_waddr     = addr_pick[$urandom_range(0, 3)];
         wb_cp0_wdata     = $urandom;
         redirect_ready   = $urandom_range(0, 1);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
